adc_mux_capture: RTL and testbench

ADC_MUX_CAPTURE -- requirements
Module: adc_mux_capture

---
 rtl/adc_mux_capture.sv | 155 +++++++++++++++
 tb/tb_adc_mux_capture.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_mux_capture.sv
// Multiplexed ADC word capture: demultiplexes NCH channels from one sample stream,
// converts offset-binary to two's complement and forwards decimated frames.
module adc_mux_capture #(
  parameter int DATA_W = 14,
  parameter int NCH    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    ch_sync,
  input  logic                    start,
  input  logic                    abort,
  input  logic [15:0]             num_frames,
  input  logic [7:0]              decim,
  output logic [NCH*DATA_W-1:0]   data_out,
  output logic [NCH-1:0]          ovr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic                    sync_err
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [IW-1:0]          next_idx;
  logic [IW-1:0]          cur_idx;
  logic [DATA_W-1:0]      lane_data [NCH];
  logic [NCH-1:0]         lane_ovr;
  logic [NCH*DATA_W-1:0]  lane_pack;
  logic [15:0]            nf_q;
  logic [15:0]            frame_cnt;
  logic [15:0]            frame_inc;
  logic [7:0]             decim_q;
  logic [7:0]             dec_cnt;
  logic                   load_pend;
  logic                   raw_ovr;
  logic                   start_go;
  logic                   sync_slip;
  logic                   frame_complete;
  logic                   load_go;
  logic                   load_accept;
  logic                   load_drop;
  logic                   last_frame;

  // A sync word always realigns the stream to channel 0.
  assign cur_idx        = ch_sync ? '0 : next_idx;
  assign raw_ovr        = (&data_in) || (data_in == '0);
  assign start_go       = (state == IDLE) && start && !abort;
  assign sync_slip      = (state == CAPTURE) && ch_sync && (next_idx != '0) && !abort;
  assign frame_complete = (state == CAPTURE) && (cur_idx == LAST_IDX) && !abort;
  assign load_go        = load_pend && !abort;
  assign load_accept    = load_go && (!out_valid || out_ready);
  assign load_drop      = load_go && out_valid && !out_ready;
  assign frame_inc      = frame_cnt + 16'd1;
  assign last_frame     = load_accept && (nf_q != 16'd0) && (frame_inc == nf_q);
  assign busy           = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)      state_next = ARMED;
      ARMED:   if (ch_sync)    state_next = CAPTURE;
      CAPTURE: if (last_frame) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Staging lanes run in every state; only frame completion is gated by CAPTURE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_idx <= '0;
      lane_ovr <= '0;
      for (int c = 0; c < NCH; c++) lane_data[c] <= '0;
    end else begin
      next_idx           <= (cur_idx == LAST_IDX) ? '0 : cur_idx + IW'(1);
      lane_data[cur_idx] <= {~data_in[DATA_W-1], data_in[DATA_W-2:0]};
      lane_ovr[cur_idx]  <= raw_ovr;
    end
  end

  always_comb begin
    lane_pack = '0;
    for (int c = 0; c < NCH; c++) begin
      lane_pack[(NCH-c)*DATA_W-1 -: DATA_W] = lane_data[c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nf_q      <= '0;
      decim_q   <= '0;
      frame_cnt <= '0;
      dec_cnt   <= '0;
      load_pend <= 1'b0;
      overflow  <= 1'b0;
      sync_err  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= last_frame;
      load_pend <= 1'b0;
      if (start_go) begin
        nf_q      <= num_frames;
        decim_q   <= decim;
        frame_cnt <= '0;
        dec_cnt   <= '0;
        overflow  <= 1'b0;
        sync_err  <= 1'b0;
      end else begin
        if (sync_slip)   sync_err  <= 1'b1;
        if (load_drop)   overflow  <= 1'b1;
        if (load_accept) frame_cnt <= frame_inc;
        // The forwarding decision is taken at completion; the load follows one edge later.
        if (frame_complete) begin
          load_pend <= (dec_cnt == 8'd0);
          dec_cnt   <= (dec_cnt == decim_q) ? 8'd0 : dec_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      ovr       <= '0;
      out_valid <= 1'b0;
    end else if (load_accept) begin
      data_out  <= lane_pack;
      ovr       <= lane_ovr;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_mux_capture.sv
// Self-checking bench for adc_mux_capture: conversion table, hand-written corner
// sequences and randomized captures compared against a frame-level reference model.
module tb_adc_mux_capture;

  localparam int DATA_W = 14;
  localparam int NCH    = 2;
  localparam int FW     = NCH * DATA_W;
  localparam int MID    = 1 << (DATA_W - 1);
  localparam int FULL   = (1 << DATA_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] data_in;
  logic              ch_sync;
  logic              start;
  logic              abort;
  logic [15:0]       num_frames;
  logic [7:0]        decim;
  logic [FW-1:0]     data_out;
  logic [NCH-1:0]    ovr;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              overflow;
  logic              sync_err;

  int checks = 0;
  int errors = 0;

  logic [FW-1:0]  monData [$];
  logic [NCH-1:0] monOvr  [$];
  int             doneSeen = 0;

  typedef struct {
    logic [DATA_W-1:0] raw0;
    logic [DATA_W-1:0] raw1;
    logic [FW-1:0]     expData;
    logic [NCH-1:0]    expOvr;
  } vec_t;

  vec_t vecs [4];

  adc_mux_capture #(.DATA_W(DATA_W), .NCH(NCH)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .ch_sync    (ch_sync),
    .start      (start),
    .abort      (abort),
    .num_frames (num_frames),
    .decim      (decim),
    .data_out   (data_out),
    .ovr        (ovr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  // Transfers and done pulses are recorded mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      monData.push_back(data_out);
      monOvr.push_back(ovr);
    end
    if (done) doneSeen++;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic s);
    data_in = d;
    ch_sync = s;
    tick();
  endtask

  task automatic pulseStart(input int nf, input int dec);
    start      = 1'b1;
    num_frames = 16'(nf);
    decim      = 8'(dec);
    applyStimulus(DATA_W'(16'h0ABC), 1'b0);
    start      = 1'b0;
  endtask

  function automatic logic [FW-1:0] refFrame(input int unsigned raw [NCH]);
    logic [FW-1:0]     f;
    logic [DATA_W-1:0] t;
    int                s;
    f = '0;
    for (int c = 0; c < NCH; c++) begin
      s = int'(raw[c]) - MID;
      t = s[DATA_W-1:0];
      f = (f << DATA_W) | FW'(t);
    end
    return f;
  endfunction

  function automatic logic [NCH-1:0] refOvr(input int unsigned raw [NCH]);
    logic [NCH-1:0] o;
    o = '0;
    for (int c = 0; c < NCH; c++) o[c] = (raw[c] == 0) || (raw[c] == FULL);
    return o;
  endfunction

  function automatic int unsigned rawWord();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 0;
    if (r == 1) return FULL;
    return $urandom_range(0, FULL);
  endfunction

  // Captures a generated stream and compares every forwarded frame with the model.
  task automatic runCapture(input int nf, input int dec, input int ngroups, input int pre,
                            input bit inject, input string tag);
    int unsigned    wq [$];
    bit             sq [$];
    logic [FW-1:0]  expD [$];
    logic [NCH-1:0] expO [$];
    int unsigned    lanes [NCH];
    int             pos;
    int             expectPos;
    int             completed;
    int             forwarded;
    bit             capturing;
    bit             finished;
    bit             expErr;
    int             base;
    int             doneBase;
    int             got;
    int             n;

    for (int i = 0; i < pre; i++) begin
      wq.push_back(rawWord());
      sq.push_back(1'b0);
    end
    for (int g = 0; g < ngroups; g++) begin
      if (inject && ($urandom_range(0, 3) == 0)) begin
        wq.push_back(rawWord());
        sq.push_back(1'b1);
      end
      for (int c = 0; c < NCH; c++) begin
        wq.push_back(rawWord());
        sq.push_back(c == 0);
      end
    end
    wq.push_back(rawWord());
    sq.push_back(1'b0);

    for (int c = 0; c < NCH; c++) lanes[c] = 0;
    pos = 0; completed = 0; forwarded = 0;
    capturing = 1'b0; finished = 1'b0; expErr = 1'b0;
    foreach (wq[i]) begin
      if (finished) continue;
      if (!capturing) begin
        if (sq[i]) begin
          capturing = 1'b1;
          pos = 0;
          lanes[0] = wq[i];
        end
        continue;
      end
      expectPos = (pos + 1) % NCH;
      if (sq[i]) begin
        if (expectPos != 0) expErr = 1'b1;
        pos = 0;
      end else begin
        pos = expectPos;
      end
      lanes[pos] = wq[i];
      if (pos == NCH - 1) begin
        if ((completed % (dec + 1)) == 0) begin
          expD.push_back(refFrame(lanes));
          expO.push_back(refOvr(lanes));
          forwarded++;
          if ((nf != 0) && (forwarded == nf)) finished = 1'b1;
        end
        completed++;
      end
    end

    base     = monData.size();
    doneBase = doneSeen;
    out_ready = 1'b1;
    pulseStart(nf, dec);
    foreach (wq[i]) applyStimulus(DATA_W'(wq[i]), sq[i]);
    checkOutput({tag, "_busy_before_abort"}, 64'(busy), 64'(!finished));
    abort = 1'b1;
    applyStimulus(DATA_W'(rawWord()), 1'b0);
    abort = 1'b0;
    checkOutput({tag, "_busy_after_abort"}, 64'(busy), 64'd0);
    applyStimulus(DATA_W'(rawWord()), 1'b0);
    applyStimulus(DATA_W'(rawWord()), 1'b0);

    got = monData.size() - base;
    checkOutput({tag, "_frame_count"}, 64'(got), 64'(expD.size()));
    n = (got < expD.size()) ? got : expD.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_data"}, 64'(monData[base + i]), 64'(expD[i]));
      checkOutput({tag, "_ovr"}, 64'(monOvr[base + i]), 64'(expO[i]));
    end
    checkOutput({tag, "_done_pulses"}, 64'(doneSeen - doneBase), 64'(finished));
    checkOutput({tag, "_overflow"}, 64'(overflow), 64'd0);
    checkOutput({tag, "_sync_err"}, 64'(sync_err), 64'(expErr));
  endtask

  initial begin
    int unsigned fa [NCH];
    int unsigned fc [NCH];
    int          base;

    rst = 1'b1; start = 1'b0; abort = 1'b0; ch_sync = 1'b0;
    data_in = '0; num_frames = '0; decim = '0; out_ready = 1'b1;

    vecs[0] = '{raw0: 14'h0000, raw1: 14'h3FFF, expData: 28'h8001FFF, expOvr: 2'b11};
    vecs[1] = '{raw0: 14'h2000, raw1: 14'h1FFF, expData: 28'h0003FFF, expOvr: 2'b00};
    vecs[2] = '{raw0: 14'h3FFF, raw1: 14'h0001, expData: 28'h7FFE001, expOvr: 2'b01};
    vecs[3] = '{raw0: 14'h1234, raw1: 14'h3FFE, expData: 28'hC8D1FFE, expOvr: 2'b00};

    #1;
    checkOutput("reset_outputs", 64'({data_out, ovr, out_valid, busy, done, overflow, sync_err}), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] conversion table");
    for (int v = 0; v < 4; v++) begin
      pulseStart(1, 0);
      applyStimulus(vecs[v].raw0, 1'b1);
      applyStimulus(vecs[v].raw1, 1'b0);
      checkOutput("vec_valid_after_last_word", 64'(out_valid), 64'd0);
      applyStimulus(DATA_W'(16'h0055), 1'b0);
      checkOutput("vec_valid_next_edge", 64'(out_valid), 64'd1);
      checkOutput("vec_data", 64'(data_out), 64'(vecs[v].expData));
      checkOutput("vec_ovr", 64'(ovr), 64'(vecs[v].expOvr));
      checkOutput("vec_done", 64'(done), 64'd1);
      checkOutput("vec_busy", 64'(busy), 64'd0);
      applyStimulus(DATA_W'(16'h0055), 1'b0);
      checkOutput("vec_valid_cleared", 64'(out_valid), 64'd0);
      checkOutput("vec_done_single", 64'(done), 64'd0);
    end

    $display("[TB] overflow with held frame");
    base = monData.size();
    out_ready = 1'b0;
    pulseStart(2, 0);
    applyStimulus(DATA_W'(16'h0100), 1'b1);
    applyStimulus(DATA_W'(16'h0200), 1'b0);
    applyStimulus(DATA_W'(16'h0300), 1'b1);
    applyStimulus(DATA_W'(16'h0400), 1'b0);
    applyStimulus(DATA_W'(16'h0500), 1'b1);
    fa = '{32'h0100, 32'h0200};
    fc = '{32'h0500, 32'h0600};
    checkOutput("ovf_valid_held", 64'(out_valid), 64'd1);
    checkOutput("ovf_data_held", 64'(data_out), 64'(refFrame(fa)));
    checkOutput("ovf_flag", 64'(overflow), 64'd1);
    checkOutput("ovf_no_done", 64'(done), 64'd0);
    checkOutput("ovf_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    applyStimulus(DATA_W'(16'h0600), 1'b0);
    checkOutput("ovf_single_transfer", 64'(out_valid), 64'd0);
    applyStimulus(DATA_W'(16'h0700), 1'b1);
    checkOutput("ovf_next_load", 64'(out_valid), 64'd1);
    checkOutput("ovf_next_data", 64'(data_out), 64'(refFrame(fc)));
    checkOutput("ovf_done_at_count2", 64'(done), 64'd1);
    checkOutput("ovf_idle", 64'(busy), 64'd0);
    applyStimulus(DATA_W'(16'h0000), 1'b0);
    checkOutput("ovf_transfer_count", 64'(monData.size() - base), 64'd2);
    if (monData.size() - base == 2) begin
      checkOutput("ovf_first_transfer", 64'(monData[base]), 64'(refFrame(fa)));
      checkOutput("ovf_second_transfer", 64'(monData[base + 1]), 64'(refFrame(fc)));
    end

    $display("[TB] sync slip");
    base = monData.size();
    pulseStart(1, 0);
    applyStimulus(DATA_W'(16'h0111), 1'b1);
    applyStimulus(DATA_W'(16'h2222), 1'b1);
    checkOutput("slip_sync_err", 64'(sync_err), 64'd1);
    applyStimulus(DATA_W'(16'h1333), 1'b0);
    applyStimulus(DATA_W'(16'h0000), 1'b0);
    fa = '{32'h2222, 32'h1333};
    checkOutput("slip_realigned_data", 64'(data_out), 64'(refFrame(fa)));
    checkOutput("slip_done", 64'(done), 64'd1);
    applyStimulus(DATA_W'(16'h0000), 1'b0);
    checkOutput("slip_single_frame", 64'(monData.size() - base), 64'd1);

    $display("[TB] model-checked captures");
    runCapture(3, 1, 6, 0, 1'b0, "decim_nf3");
    runCapture(0, 0, 20, 2, 1'b0, "continuous20");
    for (int r = 0; r < 8; r++) begin
      runCapture($urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(3, 10),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), "random");
    end

    $display("[TB] reset mid-capture and start/abort collision");
    out_ready = 1'b0;
    pulseStart(0, 0);
    applyStimulus(DATA_W'(16'h0000), 1'b1);
    applyStimulus(DATA_W'(16'h0000), 1'b1);
    applyStimulus(DATA_W'(16'h3FFF), 1'b0);
    applyStimulus(DATA_W'(16'h0001), 1'b0);
    checkOutput("rst_pre_valid", 64'(out_valid), 64'd1);
    checkOutput("rst_pre_sync_err", 64'(sync_err), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_clear", 64'({data_out, ovr, out_valid, busy, done, overflow, sync_err}), 64'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    applyStimulus(DATA_W'(16'h0000), 1'b0);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start_abort_busy", 64'(busy), 64'd0);
    applyStimulus(DATA_W'(16'h0123), 1'b1);
    applyStimulus(DATA_W'(16'h0456), 1'b0);
    applyStimulus(DATA_W'(16'h0000), 1'b0);
    checkOutput("start_abort_still_idle", 64'(busy), 64'd0);
    checkOutput("start_abort_no_frame", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
